// File: rtl/qos_egress_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// qos_egress_arbiter_pkg
// Shared constants and helpers for the QoS egress arbiter:
//   - number of virtual channels and default word width
//   - field positions of class / destination / payload inside a word
//   - default WRR weights and the weight-normalising helper
// ---------------------------------------------------------------------------
package qos_egress_arbiter_pkg;

    localparam int NUM_VC       = 4;
    localparam int DEF_DATA_W   = 12;
    localparam int DEF_WEIGHT_W = 4;

    localparam int CLASS_MSB = 11;
    localparam int CLASS_LSB = 10;
    localparam int DEST_MSB  = 9;
    localparam int DEST_LSB  = 8;

    localparam int DEF_W0 = 4;
    localparam int DEF_W1 = 3;
    localparam int DEF_W2 = 2;
    localparam int DEF_W3 = 1;

    typedef logic [1:0] vc_idx_t;

    // Word layout with the default width.
    typedef struct packed {
        logic [1:0] cls;
        logic [1:0] dest;
        logic [7:0] payload;
    } qos_word_t;

    // A weight of zero would starve a VC forever; it is promoted to one grant.
    function automatic int eff_weight(input int w);
        return (w <= 0) ? 1 : w;
    endfunction

    function automatic logic [NUM_VC-1:0] vc_onehot(input vc_idx_t idx);
        logic [NUM_VC-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/qos_egress_arbiter_if.sv
// ---------------------------------------------------------------------------
// qos_egress_arbiter_if
// Groups the VC FIFO side and the output FIFO side of the egress arbiter.
//   vc_empty        : empty flags of VC FIFOs 3..0
//   vc_data         : FWFT head words, VCi at [i*DATA_W +: DATA_W]
//   out_almost_full : almost-full flags of output FIFOs 3..0
//   vc_pop          : one-hot pop to the granted VC FIFO (combinational)
//   out_push        : one-hot push to the output FIFO chosen by dest (registered)
//   out_data        : word accompanying out_push
//   active_vc       : current WRR pointer (status)
//   idle            : no VC eligible this cycle
//
// Flow control: a VC FIFO head is valid while its empty flag is low and is
// consumed on the rising edge where the matching vc_pop bit is high. An output
// FIFO accepts a word on every edge where its out_push bit is high; it raises
// almost_full while at least one slot is still free, so the single word already
// sitting in the output register can always land.
// ---------------------------------------------------------------------------
interface qos_egress_arbiter_if #(
    parameter int DATA_W = 12
);
    import qos_egress_arbiter_pkg::*;

    logic [NUM_VC-1:0]        vc_empty;
    logic [NUM_VC*DATA_W-1:0] vc_data;
    logic [NUM_VC-1:0]        out_almost_full;
    logic [NUM_VC-1:0]        vc_pop;
    logic [NUM_VC-1:0]        out_push;
    logic [DATA_W-1:0]        out_data;
    logic [1:0]               active_vc;
    logic                     idle;

    // Arbiter side.
    modport slave (
        input  vc_empty, vc_data, out_almost_full,
        output vc_pop, out_push, out_data, active_vc, idle
    );

    // Environment side (FIFOs).
    modport master (
        output vc_empty, vc_data, out_almost_full,
        input  vc_pop, out_push, out_data, active_vc, idle
    );

endinterface

// File: rtl/qos_egress_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// qos_rr_pick
// Combinational round-robin search. Returns the first set bit of i_elig
// scanning i_ptr+1, i_ptr+2, i_ptr+3 and finally i_ptr itself (mod 4).
//   i_elig  : eligibility vector, one bit per VC
//   i_ptr   : current pointer
//   o_found : at least one VC is eligible
//   o_idx   : index of the selected VC (i_ptr when nothing is found)
// ---------------------------------------------------------------------------
module qos_rr_pick
    import qos_egress_arbiter_pkg::*;
(
    input  logic [NUM_VC-1:0] i_elig,
    input  logic [1:0]        i_ptr,
    output logic              o_found,
    output logic [1:0]        o_idx
);

    logic [1:0] w_cand;

    // Scan from the farthest offset down so the nearest eligible VC wins.
    // Offset 4 wraps to i_ptr itself, making the current VC the last choice.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_ptr;
        w_cand  = i_ptr;
        for (int s = NUM_VC; s >= 1; s--) begin
            w_cand = i_ptr + 2'(s);
            if (i_elig[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/qos_egress_arbiter.sv
// ---------------------------------------------------------------------------
// qos_egress_arbiter
// Pops words from four FWFT VC FIFOs with weighted round-robin and routes each
// word to one of four output FIFOs selected by its destination field, skipping
// VCs whose target output FIFO is almost full.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : qos_egress_arbiter_if.slave (VC FIFO side, output FIFO side, status)
// ---------------------------------------------------------------------------
module qos_egress_arbiter
    import qos_egress_arbiter_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int W0       = DEF_W0,
    parameter int W1       = DEF_W1,
    parameter int W2       = DEF_W2,
    parameter int W3       = DEF_W3
)(
    input logic                 clk,
    input logic                 reset,
    qos_egress_arbiter_if.slave bus
);

    // Credit loaded at reset (VC0 owns the first turn) and on starting a new
    // turn; the granting cycle itself consumes one, hence the minus one.
    localparam logic [WEIGHT_W-1:0] C_RESET = WEIGHT_W'(eff_weight(W0));
    localparam logic [WEIGHT_W-1:0] C_TURN0 = WEIGHT_W'(eff_weight(W0) - 1);
    localparam logic [WEIGHT_W-1:0] C_TURN1 = WEIGHT_W'(eff_weight(W1) - 1);
    localparam logic [WEIGHT_W-1:0] C_TURN2 = WEIGHT_W'(eff_weight(W2) - 1);
    localparam logic [WEIGHT_W-1:0] C_TURN3 = WEIGHT_W'(eff_weight(W3) - 1);

    logic [1:0]          r_active_vc;
    logic [WEIGHT_W-1:0] r_credit;
    logic [NUM_VC-1:0]   r_out_push;
    logic [DATA_W-1:0]   r_out_data;

    logic [DATA_W-1:0]   w_head [NUM_VC];
    logic [NUM_VC-1:0]   w_elig;
    logic                w_keep;
    logic                w_found;
    logic                w_grant;
    logic [1:0]          w_pick_idx;
    logic [1:0]          w_grant_idx;
    logic [DATA_W-1:0]   w_grant_word;

    function automatic logic [WEIGHT_W-1:0] turn_credit(input logic [1:0] idx);
        case (idx)
            2'd0:    turn_credit = C_TURN0;
            2'd1:    turn_credit = C_TURN1;
            2'd2:    turn_credit = C_TURN2;
            default: turn_credit = C_TURN3;
        endcase
    endfunction

    // A VC is eligible when it has a head word and that word's output FIFO can
    // take it. Blocked VCs are simply skipped, so one full output never stalls
    // traffic bound elsewhere.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            w_head[i] = bus.vc_data[i*DATA_W +: DATA_W];
            w_elig[i] = !bus.vc_empty[i] &&
                        !bus.out_almost_full[w_head[i][DEST_MSB:DEST_LSB]];
        end
    end

    qos_rr_pick u_rr_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_active_vc),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    // Stay on the current VC while it has credit and is eligible; otherwise the
    // round-robin search picks the next VC (current VC last).
    always_comb begin
        w_keep       = w_elig[r_active_vc] && (r_credit != '0);
        w_grant      = w_keep || w_found;
        w_grant_idx  = w_keep ? r_active_vc : w_pick_idx;
        w_grant_word = w_head[w_grant_idx];
    end

    assign bus.vc_pop    = (reset && w_grant) ? vc_onehot(w_grant_idx) : '0;
    assign bus.idle      = !(|w_elig);
    assign bus.out_push  = r_out_push;
    assign bus.out_data  = r_out_data;
    assign bus.active_vc = r_active_vc;

    // Pointer and credit: credit belongs to the turn, so switching VCs (even
    // when the old VC still had credit but went ineligible) starts a new turn.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active_vc <= '0;
            r_credit    <= C_RESET;
        end else if (w_grant) begin
            if (w_keep) begin
                r_credit <= r_credit - WEIGHT_W'(1);
            end else begin
                r_active_vc <= w_grant_idx;
                r_credit    <= turn_credit(w_grant_idx);
            end
        end
    end

    // Output register: one cycle after the pop, the word is pushed to the
    // output FIFO its destination field selects. Reset drops an in-flight word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_push <= '0;
            r_out_data <= '0;
        end else begin
            r_out_push <= w_grant ? vc_onehot(w_grant_word[DEST_MSB:DEST_LSB]) : '0;
            if (w_grant) begin
                r_out_data <= w_grant_word;
            end
        end
    end

endmodule
